// File: rtl/fifo_port_arbiter_pkg.sv
// Shared types and constants for the two-port FIFO arbiter.
// No logic, so there is no latency and no backpressure.
package fifo_ctrl_pkg;

    localparam int DATA_W_DEF = 15;
    localparam int ADDR_W_DEF = 3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        RDATA,
        FLUSH
    } state_t;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fifo_port_arbiter_if.sv
// Requester-side bundle: requests, operations, data, flush and FIFO status.
// No latency; requests are held by the master until the matching grant pulse.
interface fifo_port_arbiter_if
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic [1:0]        req;
    logic [1:0]        op;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              flush;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;

    modport master (
        output req, op, wdata0, wdata1, flush,
        input  gnt, rvalid, rdata, full, empty, count
    );

    modport slave (
        input  req, op, wdata0, wdata1, flush,
        output gnt, rvalid, rdata, full, empty, count
    );

endinterface

// File: rtl/fifo_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick among eligible requests; combinational, zero latency.
// No backpressure: an empty eligible vector simply yields no winner.
module rr_arbiter2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic [1:0] win,
    output logic       win_vld
);

    always_comb begin
        win = 2'b00;
        case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            // Tie goes to whoever was not served most recently.
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

    assign win_vld = |elig;

endmodule

// File: rtl/fifo_port_arbiter.sv
// Arbitrated read/write sequencer for a shared sync FIFO memory; grant 1 cycle after IDLE sample, read data 1 cycle after grant.
// Ineligible requests (write when full, read when empty) stay pending without a grant until the FIFO state allows them.
module fifo_port_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_port_arbiter_if.slave  port,
    output logic                mem_wen,
    output logic                mem_ren,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t            state;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              last;
    logic              sel;
    logic [1:0]        gnt_r;
    logic [1:0]        rvalid_r;
    logic              full_i;
    logic              empty_i;
    logic [1:0]        elig;
    logic [1:0]        win;
    logic              win_vld;

    // Flags decode straight from the pointer registers, so they settle one
    // cycle after the pointer moves and are stable whenever IDLE looks at them.
    assign empty_i = (wr_ptr == rd_ptr);
    assign full_i  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign port.empty  = empty_i;
    assign port.full   = full_i;
    assign port.count  = wr_ptr - rd_ptr;
    assign port.gnt    = gnt_r;
    assign port.rvalid = rvalid_r;
    assign port.rdata  = (state == RDATA) ? mem_rdata : '0;

    always_comb begin
        elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            elig[i] = port.req[i] && ((port.op[i] == OP_WRITE) ? !full_i : !empty_i);
        end
    end

    rr_arbiter2 u_arb (
        .elig    (elig),
        .last    (last),
        .win     (win),
        .win_vld (win_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last        <= 1'b1;
            sel         <= 1'b0;
            gnt_r       <= 2'b00;
            rvalid_r    <= 2'b00;
            mem_wen     <= 1'b0;
            mem_ren     <= 1'b0;
            mem_wr_addr <= '0;
            mem_rd_addr <= '0;
            mem_wdata   <= '0;
        end else begin
            gnt_r    <= 2'b00;
            rvalid_r <= 2'b00;
            mem_wen  <= 1'b0;
            mem_ren  <= 1'b0;
            case (state)
                IDLE: begin
                    if (port.flush) begin
                        state <= FLUSH;
                    end else if (win_vld) begin
                        sel   <= win[1];
                        last  <= win[1];
                        gnt_r <= win;
                        if (port.op[win[1]] == OP_WRITE) begin
                            state       <= WRITE;
                            mem_wen     <= 1'b1;
                            mem_wr_addr <= wr_ptr[ADDR_W-1:0];
                            mem_wdata   <= win[1] ? port.wdata1 : port.wdata0;
                        end else begin
                            state       <= READ;
                            mem_ren     <= 1'b1;
                            mem_rd_addr <= rd_ptr[ADDR_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    state  <= IDLE;
                end
                READ: begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    rvalid_r <= idx_onehot(sel);
                    state    <= RDATA;
                end
                RDATA: begin
                    state <= IDLE;
                end
                FLUSH: begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Randomized scoreboard bench for fifo_port_arbiter with a queue-based FIFO model and a behavioural memory.
module tb_fifo_port_arbiter;
    import fifo_ctrl_pkg::*;

    localparam int DW    = 15;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) ifc ();

    logic          mem_wen, mem_ren;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] mem [DEPTH];

    fifo_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .port        (ifc.slave),
        .mem_wen     (mem_wen),
        .mem_ren     (mem_ren),
        .mem_wr_addr (mem_wr_addr),
        .mem_rd_addr (mem_rd_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Synchronous storage with registered read data.
    always @(posedge clk) begin
        if (mem_wen) mem[mem_wr_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_rd_addr];
    end

    typedef struct {
        bit            is_rv;
        int            idx;
        bit            op;
        int            addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] mq[$];
    int            wp, rp, last_g;
    int            compared   = 0;
    int            mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        compared++;
        if (act !== req_v) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Monitor: pops an expected event for every grant or read-valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ifc.gnt != 2'b00) begin
                    if (expq.size() == 0) begin
                        check("unexpected_gnt", 32'(ifc.gnt), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check("gnt_event_kind", 32'(e.is_rv), 32'd0);
                        check("gnt_onehot", 32'(ifc.gnt), 32'd1 << e.idx);
                        if (e.op) begin
                            check("wr_mem_wen", 32'(mem_wen), 32'd1);
                            check("wr_mem_ren", 32'(mem_ren), 32'd0);
                            check("wr_addr", 32'(mem_wr_addr), 32'(e.addr));
                            check("wr_data", 32'(mem_wdata), 32'(e.data));
                        end else begin
                            check("rd_mem_ren", 32'(mem_ren), 32'd1);
                            check("rd_mem_wen", 32'(mem_wen), 32'd0);
                            check("rd_addr", 32'(mem_rd_addr), 32'(e.addr));
                        end
                    end
                end else if (mem_wen || mem_ren) begin
                    check("enable_without_gnt", {30'd0, mem_wen, mem_ren}, 32'd0);
                end
                if (ifc.rvalid != 2'b00) begin
                    if (expq.size() == 0) begin
                        check("unexpected_rvalid", 32'(ifc.rvalid), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check("rv_event_kind", 32'(e.is_rv), 32'd1);
                        check("rvalid_onehot", 32'(ifc.rvalid), 32'd1 << e.idx);
                        check("rdata", 32'(ifc.rdata), 32'(e.data));
                    end
                end
            end
        end
    end

    task automatic check_flags(input string tag);
        check({tag, "_count"}, 32'(ifc.count), 32'(mq.size()));
        check({tag, "_empty"}, 32'(ifc.empty), 32'(mq.size() == 0));
        check({tag, "_full"},  32'(ifc.full),  32'(mq.size() == DEPTH));
    endtask

    task automatic model_clear();
        mq.delete();
        wp = 0;
        rp = 0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        ifc.req    = 2'b00;
        ifc.flush  = 1'b0;
        expq.delete();
        model_clear();
        last_g = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_flush();
        @(posedge clk);
        #1 ifc.flush = 1'b1;
        @(posedge clk);
        #1 ifc.flush = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_flags("flush");
    endtask

    // Plans the grant order from FIFO occupancy and round-robin fairness,
    // asserts only the requests that will eventually be served, then drives
    // the handshake until every planned grant has been seen.
    task automatic run_round(input bit [1:0] want, input bit [1:0] ops,
                             input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input bit flush_on_read);
        bit [1:0] pend = want;
        bit [1:0] plan = 2'b00;
        bit [1:0] el;
        int       w, need, granted, cyc;
        exp_t     e;
        forever begin
            el = 2'b00;
            for (int i = 0; i < 2; i++)
                if (pend[i]) el[i] = ops[i] ? (mq.size() < DEPTH) : (mq.size() > 0);
            if (el == 2'b00) break;
            w = (el == 2'b11) ? (1 - last_g) : (el[1] ? 1 : 0);
            pend[w] = 1'b0;
            plan[w] = 1'b1;
            last_g  = w;
            e.is_rv = 1'b0;
            e.idx   = w;
            e.op    = ops[w];
            if (ops[w]) begin
                e.addr = wp % DEPTH;
                e.data = (w == 1) ? d1 : d0;
                mq.push_back(e.data);
                wp = (wp + 1) % (2 * DEPTH);
                expq.push_back(e);
            end else begin
                e.addr = rp % DEPTH;
                e.data = '0;
                expq.push_back(e);
                e.is_rv = 1'b1;
                e.data  = mq.pop_front();
                rp = (rp + 1) % (2 * DEPTH);
                expq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        ifc.op     = ops;
        ifc.wdata0 = d0;
        ifc.wdata1 = d1;
        ifc.req    = plan;
        need    = $countones(plan);
        granted = 0;
        cyc     = 0;
        while (granted < need && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (ifc.req[i] && ifc.gnt[i]) begin
                    ifc.req[i] = 1'b0;
                    granted++;
                    if (flush_on_read && !ops[i]) begin
                        ifc.flush = 1'b1;
                        repeat (3) @(posedge clk);
                        #1 ifc.flush = 1'b0;
                        model_clear();
                    end
                end
            end
        end
        if (granted < need) begin
            check("round_timeout", 32'(granted), 32'(need));
            ifc.req = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        check_flags("round");
    endtask

    initial begin
        ifc.req    = 2'b00;
        ifc.op     = 2'b00;
        ifc.wdata0 = '0;
        ifc.wdata1 = '0;
        ifc.flush  = 1'b0;
        do_reset();

        // Reset values
        @(posedge clk);
        #1;
        check_flags("reset");
        check("reset_gnt", 32'(ifc.gnt), 32'd0);
        check("reset_rvalid", 32'(ifc.rvalid), 32'd0);
        check("reset_wr_addr", 32'(mem_wr_addr), 32'd0);
        check("reset_wdata", 32'(mem_wdata), 32'd0);

        // Reset asserted while a write is in flight
        ifc.op = 2'b01; ifc.wdata0 = 15'h1234; ifc.req = 2'b01;
        begin
            int n = 0;
            while (!ifc.gnt[0] && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("midwrite_gnt_seen", 32'(ifc.gnt[0]), 32'd1);
        end
        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("post_reset_gnt", 32'(ifc.gnt), 32'd0);
            check("post_reset_wen", 32'(mem_wen), 32'd0);
            check("post_reset_empty", 32'(ifc.empty), 32'd1);
            check("post_reset_count", 32'(ifc.count), 32'd0);
        end

        // Fill to full, then a pending write that waits for a read
        for (int k = 1; k <= DEPTH; k++) run_round(2'b01, 2'b01, 15'(k), '0, 1'b0);
        @(posedge clk);
        #1;
        ifc.op = 2'b01; ifc.wdata0 = 15'h0009; ifc.req = 2'b01;
        repeat (6) @(posedge clk);
        #1;
        check("full_pending_no_gnt", 32'(ifc.gnt), 32'd0);
        ifc.req = 2'b00;
        run_round(2'b11, 2'b01, 15'h0009, '0, 1'b0);

        // Fill 8, drain 8, then a write and read across the pointer wrap
        do_flush();
        for (int k = 0; k < DEPTH; k++) run_round(2'b01, 2'b01, 15'($urandom), '0, 1'b0);
        while (mq.size() > 0) run_round(2'b10, 2'b00, '0, '0, 1'b0);
        run_round(2'b01, 2'b01, 15'h7ABC, '0, 1'b0);
        check("wrap_count_after_write", 32'(ifc.count), 32'd1);
        run_round(2'b10, 2'b00, '0, '0, 1'b0);

        // Simultaneous writers alternate
        do_flush();
        for (int k = 0; k < 4; k++)
            run_round(2'b11, 2'b11, 15'(16'h0100 + k), 15'(16'h0200 + k), 1'b0);

        // Read while empty alongside an eligible write
        do_flush();
        run_round(2'b11, 2'b01, 15'h0005, '0, 1'b0);

        // Flush held from the READ cycle onward
        run_round(2'b01, 2'b01, 15'h0A0A, '0, 1'b0);
        run_round(2'b01, 2'b01, 15'h0B0B, '0, 1'b0);
        run_round(2'b10, 2'b00, '0, '0, 1'b1);

        // Randomized traffic
        for (int r = 0; r < 250; r++) begin
            if ($urandom_range(0, 11) == 0) do_flush();
            else run_round(2'($urandom_range(1, 3)), 2'($urandom), 15'($urandom), 15'($urandom), 1'b0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_port_arbiter.md
# fifo_port_arbiter

Two-port arbitrated controller for the 8-entry, 15-bit FIFO storage. Two requesters issue read or write operations through a req/gnt handshake. The block picks one eligible request at a time using round-robin, drives the synchronous memory's write/read enables and addresses, and owns the read/write pointers and the full, empty and occupancy status. It replaces direct button-driven sequencing of the storage when two sources share the FIFO.

## Interface
- `DATA_W`, default 15: word width.
- `ADDR_W`, default 3: memory address width; depth = 2**ADDR_W.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester request; held until the matching `gnt` pulse.
- `op`  in  2  per-requester operation: 1 = write, 0 = read; stable while `req` is high.
- `wdata0`, `wdata1`  in  DATA_W  write data per requester; stable while `req` is high.
- `flush`  in  1  synchronous pointer clear.
- `gnt`  out  2  one-hot, one-cycle grant pulse.
- `rvalid`  out  2  one-hot, one-cycle read-data-valid pulse.
- `rdata`  out  DATA_W  read data; valid only while `rvalid` is non-zero.
- `mem_wen`, `mem_ren`  out  1  memory enables.
- `mem_wr_addr`, `mem_rd_addr`  out  ADDR_W  memory addresses.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory registered read data (1-cycle latency).
- `full`, `empty`  out  1  status flags.
- `count`  out  ADDR_W+1  occupancy, 0..2**ADDR_W.

## Operation
- **Pointers:** `wr_ptr`/`rd_ptr` are ADDR_W+1 bits and wrap modulo 2**(ADDR_W+1). The memory address is the low ADDR_W bits.
- **Status:**
  - `empty` = pointers equal.
  - `full` = MSBs differ and low bits equal.
  - `count` = `wr_ptr` - `rd_ptr` (modulo).
- **Eligibility:** a write is eligible only when not `full`; a read is eligible only when not `empty`. Ineligible requests stay pending, receive no `gnt`, and are never dropped.
- **Arbitration:**
  - Round-robin over the eligible requests. The requester not granted last wins a tie.
  - The `last` register resets to 1, so requester 0 wins the first tie.
  - `last` updates only on a grant.
- **FSM states:** IDLE, WRITE, READ, RDATA, FLUSH.
  - IDLE: if `flush` is high, go to FLUSH; flush has priority over all requests. Otherwise, if any eligible request, latch the winner's index and data, then go to WRITE or READ per `op`. Otherwise stay in IDLE.
  - WRITE: `gnt[i]`=1, `mem_wen`=1, `mem_wr_addr`=`wr_ptr[ADDR_W-1:0]`, `mem_wdata`=latched data. `wr_ptr` increments at the end of the cycle. Next state IDLE.
  - READ: `gnt[i]`=1, `mem_ren`=1, `mem_rd_addr`=`rd_ptr[ADDR_W-1:0]`. `rd_ptr` increments at the end of the cycle. Next state RDATA.
  - RDATA: `rvalid[i]`=1, `rdata`=`mem_rdata`. Next state IDLE.
  - FLUSH: both pointers cleared at the end of the cycle; no grant. Next state IDLE.
- **Flush timing:** `flush` is sampled only in IDLE. A flush asserted during WRITE/READ/RDATA takes effect once the block returns to IDLE, provided it is still high.
- **Request sampling:** `req` is ignored outside IDLE. A `req` still high when IDLE is re-entered is treated as a new request.
- **Reset values:** state IDLE, pointers 0, `empty`=1, `full`=0, `count`=0. All of `gnt`, `rvalid`, `mem_wen`, `mem_ren` are 0. Addresses and `mem_wdata` are 0.
- **Reset mid-operation:** reset asserted mid-operation aborts it immediately with no pointer update. Stale memory contents become unreachable.

## Timing
- **Write:** request sampled in IDLE at cycle N; `gnt`/`mem_wen` at N+1; updated flags visible at N+2. Write throughput is one per 2 cycles.
- **Read:** request sampled in IDLE at cycle N; `gnt`/`mem_ren` at N+1; `rvalid`+`rdata` at N+2; IDLE again at N+3.
- **Outputs:** all outputs are registered or decoded from the state register only; none combinationally depends on `req`.
- **Flag timing:** status flags update the cycle after a pointer change, so eligibility evaluated in IDLE always uses settled flags.

## Structure
- **Package `fifo_ctrl_pkg`:**
  - `state_t` enum (IDLE, WRITE, READ, RDATA, FLUSH).
  - `OP_READ`=0 and `OP_WRITE`=1.
  - Default DATA_W/ADDR_W constants.
- **Sub-module `rr_arbiter2`:**
  - Inputs: 2-bit eligible-request vector and `last`.
  - Outputs: one-hot winner and valid.
  - Purely combinational. The `last` register lives in the parent.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WRITE, then release. Required: `empty`=1, `count`=0, no `gnt`/`mem_wen` for 2 cycles after release.
- **Fill to full:** requester 0 writes 0x0001..0x0008. Required: eight `gnt[0]` pulses with addresses 0..7, then `full`=1 and `count`=8. A ninth write stays pending with no `gnt`; it is granted after one read.
- **Contention:** both requesters write simultaneously, 4 times. Required: grants alternate 0,1,0,1; `mem_wdata` follows the granted `wdata`.
- **Read latency and wrap-around:** fill 8, read 8, write 0x7ABC, read it. Required: `rvalid` 2 cycles after sampling, data in FIFO order; 0x7ABC written at address 0 with `wr_ptr`=9; `rdata`=0x7ABC.
- **Empty-read plus eligible write:** requester 1 reads while empty and requester 0 writes. Required: write granted first, then the read granted and 0x0005 returned.
- **Flush during READ:** assert flush during READ and hold it. Required: `rvalid` completes, then FLUSH, then `empty`=1, `count`=0, with no grant in the FLUSH cycle.
